miriscv_lsu_misalign_ctrl: RTL and testbench

MIRISCV_LSU_MISALIGN_CTRL -- requirements
Module: miriscv_lsu_misalign_ctrl

---
 rtl/miriscv_lsu_misalign_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_miriscv_lsu_misalign_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_lsu_misalign_ctrl.sv
// Load/store controller between the core and a word-wide memory port.
// Define MIRISCV_LSU_MISALIGN_EN to split word-crossing accesses into two; without it they raise core_err_o.
module miriscv_lsu_misalign_ctrl #(
    parameter int XLEN         = 32,
    parameter int MEM_ACCESS_W = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    core_req_i,
    input  logic                    core_we_i,
    input  logic [MEM_ACCESS_W-1:0] core_size_i,
    input  logic [XLEN-1:0]         core_addr_i,
    input  logic [XLEN-1:0]         core_wdata_i,
    output logic                    core_ready_o,
    output logic                    core_rvalid_o,
    output logic [XLEN-1:0]         core_rdata_o,
    output logic                    core_err_o,
    output logic                    data_req_o,
    output logic                    data_we_o,
    output logic [3:0]              data_be_o,
    output logic [XLEN-1:0]         data_addr_o,
    output logic [XLEN-1:0]         data_wdata_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    input  logic [XLEN-1:0]         data_rdata_i
);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_e;

    localparam logic [MEM_ACCESS_W-1:0] SZ_B  = MEM_ACCESS_W'(0);
    localparam logic [MEM_ACCESS_W-1:0] SZ_H  = MEM_ACCESS_W'(1);
    localparam logic [MEM_ACCESS_W-1:0] SZ_W  = MEM_ACCESS_W'(2);
    localparam logic [MEM_ACCESS_W-1:0] SZ_BU = MEM_ACCESS_W'(4);
    localparam logic [MEM_ACCESS_W-1:0] SZ_HU = MEM_ACCESS_W'(5);

    state_e                  state_q, state_d;
    logic                    we_q, err_q, req_err, load_done;
    logic [MEM_ACCESS_W-1:0] size_q;
    logic [XLEN-1:0]         addr_q, wdata_q, rdata_q, word_addr, merged, wdata0;
    logic [3:0]              be0;
    logic [4:0]              shamt;

    // A zero mask marks the illegal size codes.
    function automatic logic [3:0] size_mask(input logic [MEM_ACCESS_W-1:0] size);
        case (size)
            SZ_B, SZ_BU: return 4'b0001;
            SZ_H, SZ_HU: return 4'b0011;
            SZ_W:        return 4'b1111;
            default:     return 4'b0000;
        endcase
    endfunction

    function automatic logic is_split(input logic [MEM_ACCESS_W-1:0] size, input logic [1:0] off);
        logic [2:0] last;
        case (size)
            SZ_H, SZ_HU: last = {1'b0, off} + 3'd1;
            SZ_W:        last = {1'b0, off} + 3'd3;
            default:     last = {1'b0, off};
        endcase
        return last > 3'd3;
    endfunction

    function automatic logic [XLEN-1:0] extend(input logic [MEM_ACCESS_W-1:0] size, input logic [XLEN-1:0] raw);
        case (size)
            SZ_B:    return {{(XLEN-8){raw[7]}}, raw[7:0]};
            SZ_H:    return {{(XLEN-16){raw[15]}}, raw[15:0]};
            SZ_BU:   return {{(XLEN-8){1'b0}}, raw[7:0]};
            SZ_HU:   return {{(XLEN-16){1'b0}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign word_addr = {addr_q[XLEN-1:2], 2'b00};
    assign shamt     = {addr_q[1:0], 3'b000};

    always_comb begin
        req_err = (size_mask(core_size_i) == 4'b0000) ||
                  (core_we_i && (core_size_i == SZ_BU || core_size_i == SZ_HU));
`ifndef MIRISCV_LSU_MISALIGN_EN
        req_err = req_err || is_split(core_size_i, core_addr_i[1:0]);
`endif
    end

`ifdef MIRISCV_LSU_MISALIGN_EN
    logic              split_cur;
    logic [7:0]        be_wide;
    logic [2*XLEN-1:0] wdata_wide;
    logic [XLEN-1:0]   rdata0_q, merge_hi, merge_lo;

    assign split_cur = is_split(size_q, addr_q[1:0]);
    assign load_done = data_rvalid_i && ((state_q == WAIT0 && !split_cur) || state_q == WAIT1);

    // Shifting into a double-width window yields both halves of a split access at once.
    always_comb begin
        be_wide    = {4'b0000, size_mask(size_q)} << addr_q[1:0];
        wdata_wide = {{XLEN{1'b0}}, wdata_q} << shamt;
        merge_hi   = (state_q == WAIT1) ? data_rdata_i : '0;
        merge_lo   = (state_q == WAIT1) ? rdata0_q : data_rdata_i;
        merged     = XLEN'({merge_hi, merge_lo} >> shamt);
        be0        = be_wide[3:0];
        wdata0     = wdata_wide[XLEN-1:0];
    end
`else
    assign load_done = data_rvalid_i && (state_q == WAIT0);

    always_comb begin
        be0    = size_mask(size_q) << addr_q[1:0];
        wdata0 = wdata_q << shamt;
        merged = data_rdata_i >> shamt;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (core_req_i) state_d = req_err ? RESP : REQ0;
            REQ0:  if (data_gnt_i) state_d = WAIT0;
`ifdef MIRISCV_LSU_MISALIGN_EN
            WAIT0: if (data_rvalid_i) state_d = split_cur ? REQ1 : RESP;
            REQ1:  if (data_gnt_i) state_d = WAIT1;
            WAIT1: if (data_rvalid_i) state_d = RESP;
`else
            WAIT0: if (data_rvalid_i) state_d = RESP;
`endif
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory port is a pure function of state and the captured request, so it stays stable until granted.
    always_comb begin
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        data_be_o    = 4'b0000;
        data_addr_o  = '0;
        data_wdata_o = '0;
        case (state_q)
            REQ0: begin
                data_req_o   = 1'b1;
                data_we_o    = we_q;
                data_be_o    = be0;
                data_addr_o  = word_addr;
                data_wdata_o = wdata0;
            end
`ifdef MIRISCV_LSU_MISALIGN_EN
            REQ1: begin
                data_req_o   = 1'b1;
                data_we_o    = we_q;
                data_be_o    = be_wide[7:4];
                data_addr_o  = word_addr + XLEN'(4);
                data_wdata_o = wdata_wide[2*XLEN-1:XLEN];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
`ifdef MIRISCV_LSU_MISALIGN_EN
            rdata0_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && core_req_i) begin
                we_q    <= core_we_i;
                err_q   <= req_err;
                size_q  <= core_size_i;
                addr_q  <= core_addr_i;
                wdata_q <= core_wdata_i;
                rdata_q <= '0;
            end
`ifdef MIRISCV_LSU_MISALIGN_EN
            if (state_q == WAIT0 && data_rvalid_i) rdata0_q <= data_rdata_i;
`endif
            if (load_done && !we_q) rdata_q <= extend(size_q, merged);
        end
    end

    assign core_ready_o  = (state_q == IDLE);
    assign core_rvalid_o = (state_q == RESP);
    assign core_err_o    = (state_q == RESP) && err_q;
    assign core_rdata_o  = rdata_q;

endmodule

// File: tb/tb_miriscv_lsu_misalign_ctrl.sv
// Directed bench for miriscv_lsu_misalign_ctrl; expectations follow MIRISCV_LSU_MISALIGN_EN if defined.
module tb_miriscv_lsu_misalign_ctrl;

    localparam logic [2:0] SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2, SZ_BU = 3'd4, SZ_HU = 3'd5;
    localparam int NV = 19;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        core_req_i = 1'b0, core_we_i = 1'b0;
    logic [2:0]  core_size_i = '0;
    logic [31:0] core_addr_i = '0, core_wdata_i = '0;
    logic        core_ready_o, core_rvalid_o, core_err_o;
    logic [31:0] core_rdata_o;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = '0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    miriscv_lsu_misalign_ctrl #(.XLEN(32), .MEM_ACCESS_W(3)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_ready_o(core_ready_o), .core_rvalid_o(core_rvalid_o),
        .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
    );

    typedef struct packed {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  gnt_delay;
        logic [3:0]  rv_delay;
        logic [31:0] rdata0;
        logic [31:0] rdata1;
        logic        err;
        logic        split;
        logic [31:0] addr0;
        logic [3:0]  be0;
        logic [31:0] wdata0;
        logic [31:0] addr1;
        logic [3:0]  be1;
        logic [31:0] wdata1;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t ld(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] rdata,
                                input logic [31:0] a0, input logic [3:0] be, input logic [31:0] exp_rdata);
        vec_t v;
        v = '0;
        v.size = size; v.addr = addr; v.rdata0 = rdata;
        v.addr0 = a0; v.be0 = be; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    function automatic vec_t ld2(input logic [2:0] size, input logic [31:0] addr,
                                 input logic [31:0] r0, input logic [31:0] r1,
                                 input logic [31:0] a0, input logic [3:0] be0,
                                 input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] exp_rdata);
        vec_t v;
        v = ld(size, addr, r0, a0, be0, exp_rdata);
        v.split = 1'b1; v.rdata1 = r1; v.addr1 = a1; v.be1 = be1;
        return v;
    endfunction

    function automatic vec_t st(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] a0, input logic [3:0] be, input logic [31:0] w0);
        vec_t v;
        v = '0;
        v.we = 1'b1; v.size = size; v.addr = addr; v.wdata = wdata;
        v.rdata0 = 32'hFFFF_FFFF; v.rdata1 = 32'hFFFF_FFFF;
        v.addr0 = a0; v.be0 = be; v.wdata0 = w0;
        return v;
    endfunction

    function automatic vec_t st2(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] w0,
                                 input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] w1);
        vec_t v;
        v = st(size, addr, wdata, a0, be0, w0);
        v.split = 1'b1; v.addr1 = a1; v.be1 = be1; v.wdata1 = w1;
        return v;
    endfunction

    function automatic vec_t er(input logic we, input logic [2:0] size, input logic [31:0] addr);
        vec_t v;
        v = '0;
        v.we = we; v.size = size; v.addr = addr; v.wdata = 32'h1234_5678; v.err = 1'b1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One memory access: hold off the grant (with a stray rvalid that must be ignored), then respond.
    task automatic serveAccess(input string tag, input logic [31:0] addr, input logic [3:0] be, input logic we,
                               input logic [31:0] wdata, input int gnt_delay, input int rv_delay,
                               input logic [31:0] rdata);
        for (int i = 0; i <= gnt_delay; i++) begin
            checkOutput({tag, "/req"}, 32'(data_req_o), 32'd1);
            checkOutput({tag, "/addr"}, data_addr_o, addr);
            checkOutput({tag, "/be"}, 32'(data_be_o), 32'(be));
            checkOutput({tag, "/we"}, 32'(data_we_o), 32'(we));
            if (we) checkOutput({tag, "/wdata"}, data_wdata_o, wdata);
            data_gnt_i    = (i == gnt_delay);
            data_rvalid_i = (i != gnt_delay);
            data_rdata_i  = 32'hBAD0_BAD0;
            tick();
        end
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        for (int i = 0; i < rv_delay; i++) begin
            checkOutput({tag, "/wait_noreq"}, 32'(data_req_o), 32'd0);
            checkOutput({tag, "/wait_norvalid"}, 32'(core_rvalid_o), 32'd0);
            tick();
        end
        data_rvalid_i = 1'b1;
        data_rdata_i  = rdata;
        tick();
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;
    endtask

    task automatic applyStimulus(input string tag, input vec_t v);
        checkOutput({tag, "/ready"}, 32'(core_ready_o), 32'd1);
        core_req_i   = 1'b1;
        core_we_i    = v.we;
        core_size_i  = v.size;
        core_addr_i  = v.addr;
        core_wdata_i = v.wdata;
        tick();
        core_req_i = 1'b0;
        if (!v.err) begin
            serveAccess({tag, "/a0"}, v.addr0, v.be0, v.we, v.wdata0, int'(v.gnt_delay), int'(v.rv_delay), v.rdata0);
            if (v.split)
                serveAccess({tag, "/a1"}, v.addr1, v.be1, v.we, v.wdata1, 0, 0, v.rdata1);
        end
        checkOutput({tag, "/noreq"}, 32'(data_req_o), 32'd0);
        checkOutput({tag, "/rvalid"}, 32'(core_rvalid_o), 32'd1);
        checkOutput({tag, "/err"}, 32'(core_err_o), 32'(v.err));
        checkOutput({tag, "/rdata"}, core_rdata_o, v.exp_rdata);
        tick();
        checkOutput({tag, "/rvalid_drop"}, 32'(core_rvalid_o), 32'd0);
        checkOutput({tag, "/ready_back"}, 32'(core_ready_o), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = ld(SZ_W,  32'h0000_0100, 32'h8000_00F0, 32'h0000_0100, 4'hF, 32'h8000_00F0);
        vecs[1]  = ld(SZ_B,  32'h0000_0103, 32'h8012_3456, 32'h0000_0100, 4'h8, 32'hFFFF_FF80);
        vecs[2]  = ld(SZ_BU, 32'h0000_0103, 32'h8012_3456, 32'h0000_0100, 4'h8, 32'h0000_0080);
        vecs[3]  = ld(SZ_H,  32'h0000_0202, 32'h7FFF_1234, 32'h0000_0200, 4'hC, 32'h0000_7FFF);
        vecs[4]  = ld(SZ_H,  32'h0000_0200, 32'h1234_ABCD, 32'h0000_0200, 4'h3, 32'hFFFF_ABCD);
        vecs[5]  = ld(SZ_HU, 32'h0000_0201, 32'h00FE_DC00, 32'h0000_0200, 4'h6, 32'h0000_FEDC);
        vecs[6]  = st(SZ_B,  32'h0000_0302, 32'hDEAD_BEA5, 32'h0000_0300, 4'h4, 32'hBEA5_0000);
        vecs[7]  = st(SZ_H,  32'h0000_0301, 32'hAAAA_5678, 32'h0000_0300, 4'h6, 32'hAA56_7800);
        vecs[8]  = st(SZ_W,  32'h0000_0400, 32'hCAFE_F00D, 32'h0000_0400, 4'hF, 32'hCAFE_F00D);
        vecs[9]  = er(1'b1, SZ_BU, 32'h0000_0500);
        vecs[10] = er(1'b0, 3'd7,  32'h0000_0500);
        vecs[11] = er(1'b0, 3'd3,  32'h0000_0504);
        vecs[12] = er(1'b1, SZ_HU, 32'h0000_0508);
`ifdef MIRISCV_LSU_MISALIGN_EN
        vecs[13] = ld2(SZ_W, 32'h0000_0102, 32'hBBAA_1111, 32'h2222_DDCC,
                       32'h0000_0100, 4'hC, 32'h0000_0104, 4'h3, 32'hDDCC_BBAA);
        vecs[14] = ld2(SZ_H, 32'h0000_0003, 32'h8500_0000, 32'h0000_00FF,
                       32'h0000_0000, 4'h8, 32'h0000_0004, 4'h1, 32'hFFFF_FF85);
        vecs[15] = st2(SZ_W, 32'h0000_00FF, 32'h1122_3344,
                       32'h0000_00FC, 4'h8, 32'h4400_0000, 32'h0000_0100, 4'h7, 32'h0011_2233);
        vecs[16] = ld2(SZ_W, 32'hFFFF_FFFE, 32'h5566_0000, 32'h0000_7788,
                       32'hFFFF_FFFC, 4'hC, 32'h0000_0000, 4'h3, 32'h7788_5566);
        vecs[17] = st2(SZ_H, 32'h0000_00FF, 32'h0000_BEEF,
                       32'h0000_00FC, 4'h8, 32'hEF00_0000, 32'h0000_0100, 4'h1, 32'h0000_00BE);
`else
        vecs[13] = er(1'b0, SZ_W, 32'h0000_0102);
        vecs[14] = er(1'b0, SZ_H, 32'h0000_0003);
        vecs[15] = er(1'b1, SZ_W, 32'h0000_00FF);
        vecs[16] = er(1'b0, SZ_W, 32'hFFFF_FFFE);
        vecs[17] = er(1'b1, SZ_H, 32'h0000_00FF);
`endif
        vecs[18] = ld(SZ_BU, 32'h0000_0000, 32'hFFFF_FF7E, 32'h0000_0000, 4'h1, 32'h0000_007E);
        vecs[3].rv_delay   = 4'd1;
        vecs[8].gnt_delay  = 4'd2;
        vecs[15].gnt_delay = 4'd3;

        tick();
        tick();
        rst_i = 1'b0;
        checkOutput("reset/ready", 32'(core_ready_o), 32'd1);
        checkOutput("reset/rvalid", 32'(core_rvalid_o), 32'd0);
        checkOutput("reset/err", 32'(core_err_o), 32'd0);
        checkOutput("reset/req", 32'(data_req_o), 32'd0);
        checkOutput("reset/we", 32'(data_we_o), 32'd0);
        checkOutput("reset/be", 32'(data_be_o), 32'd0);
        checkOutput("reset/addr", data_addr_o, 32'd0);
        checkOutput("reset/wdata", data_wdata_o, 32'd0);
        checkOutput("reset/rdata", core_rdata_o, 32'd0);

        for (int i = 0; i < NV; i++)
            applyStimulus($sformatf("v%0d", i), vecs[i]);

        // Abandon a transaction in its last wait state; the late rvalid must not produce a response.
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = SZ_W;
`ifdef MIRISCV_LSU_MISALIGN_EN
        core_addr_i = 32'h0000_0102;
`else
        core_addr_i = 32'h0000_0100;
`endif
        tick();
        core_req_i = 1'b0;
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
`ifdef MIRISCV_LSU_MISALIGN_EN
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h1111_1111;
        tick();
        data_rvalid_i = 1'b0;
        checkOutput("midrst/second_req", 32'(data_req_o), 32'd1);
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
`endif
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checkOutput("midrst/ready", 32'(core_ready_o), 32'd1);
        checkOutput("midrst/req", 32'(data_req_o), 32'd0);
        checkOutput("midrst/rvalid", 32'(core_rvalid_o), 32'd0);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h2222_2222;
        tick();
        data_rvalid_i = 1'b0;
        checkOutput("midrst/stale_rvalid", 32'(core_rvalid_o), 32'd0);
        checkOutput("midrst/stale_ready", 32'(core_ready_o), 32'd1);
        checkOutput("midrst/stale_req", 32'(data_req_o), 32'd0);
        tick();
        checkOutput("midrst/still_quiet", 32'(core_rvalid_o), 32'd0);
        applyStimulus("midrst/next", vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
